// File: rtl/frac_baud_gen.sv
// Fractional-N baud tick generator: runtime-loadable integer+fractional divisor
// producing an oversampling tick, a per-bit tick and the sample phase index.
module frac_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OSR         = 16,
    parameter int DEFAULT_DIV = 163
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    restart,
    input  logic [DIV_W-1:0]        div_int,
    input  logic [FRAC_W-1:0]       div_frac,
    input  logic                    div_load,
    output logic                    sample_tick,
    output logic                    bit_tick,
    output logic [$clog2(OSR)-1:0]  phase,
    output logic                    div_err
);

    localparam int PH_W = $clog2(OSR);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              extend_q, extend_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_valid_q, pend_valid_d;
    logic              div_err_q, div_err_d;

    logic [DIV_W:0]    period;
    logic [FRAC_W:0]   acc_sum;
    logic              valid_load;
    logic              apply;
    logic              wrap;

    always_comb begin
        period      = {1'b0, act_int_q} + {{DIV_W{1'b0}}, extend_q};
        wrap        = ({1'b0, cnt_q} == (period - {{DIV_W{1'b0}}, 1'b1}));
        sample_tick = ~reset & en & ~restart & wrap;
        bit_tick    = sample_tick & (phase_q == PH_W'(OSR - 1));
        phase       = phase_q;
        div_err     = div_err_q;
        valid_load  = div_load & (div_int >= DIV_W'(2));
        acc_sum     = {1'b0, acc_q} + {1'b0, act_frac_q};
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        extend_d     = extend_q;
        phase_d      = phase_q;
        act_int_d    = act_int_q;
        act_frac_d   = act_frac_q;
        pend_int_d   = pend_int_q;
        pend_frac_d  = pend_frac_q;
        pend_valid_d = pend_valid_q;
        div_err_d    = div_err_q;
        apply        = 1'b0;

        if (div_load) begin
            div_err_d = ~valid_load;
        end
        if (valid_load) begin
            pend_int_d   = div_int;
            pend_frac_d  = div_frac;
            pend_valid_d = 1'b1;
        end

        if (restart) begin
            cnt_d    = '0;
            acc_d    = '0;
            extend_d = 1'b0;
            phase_d  = '0;
            apply    = 1'b1;
        end else if (!en) begin
            // Frozen: a valid load takes effect at once since there is no period to finish
            if (valid_load) begin
                acc_d    = '0;
                extend_d = 1'b0;
                apply    = 1'b1;
            end
        end else if (sample_tick) begin
            cnt_d   = '0;
            phase_d = (phase_q == PH_W'(OSR - 1)) ? '0 : phase_q + PH_W'(1);
            if (valid_load || pend_valid_q) begin
                acc_d    = '0;
                extend_d = 1'b0;
                apply    = 1'b1;
            end else begin
                acc_d    = acc_sum[FRAC_W-1:0];
                extend_d = acc_sum[FRAC_W];
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // A load arriving in the apply cycle bypasses the pending registers
        if (apply) begin
            if (valid_load) begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
            end else if (pend_valid_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            extend_q     <= 1'b0;
            phase_q      <= '0;
            act_int_q    <= DIV_W'(DEFAULT_DIV);
            act_frac_q   <= '0;
            pend_int_q   <= '0;
            pend_frac_q  <= '0;
            pend_valid_q <= 1'b0;
            div_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            extend_q     <= extend_d;
            phase_q      <= phase_d;
            act_int_q    <= act_int_d;
            act_frac_q   <= act_frac_d;
            pend_int_q   <= pend_int_d;
            pend_frac_q  <= pend_frac_d;
            pend_valid_q <= pend_valid_d;
            div_err_q    <= div_err_d;
        end
    end

endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed self-checking bench for frac_baud_gen with default parameters.
module tb_frac_baud_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        restart;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        sample_tick;
    logic        bit_tick;
    logic [3:0]  phase;
    logic        div_err;

    int n_vec = 0;
    int n_err = 0;

    frac_baud_gen #(
        .DIV_W(16),
        .FRAC_W(4),
        .OSR(16),
        .DEFAULT_DIV(163)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .restart(restart),
        .div_int(div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .sample_tick(sample_tick),
        .bit_tick(bit_tick),
        .phase(phase),
        .div_err(div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until sample_tick, counting the current unsampled cycle as 1; returns max on timeout.
    task automatic wait_tick(input int max, output int n);
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < max) begin
            @(negedge clk);
            n++;
            found = sample_tick;
        end
    endtask

    // Load a divisor together with restart so it becomes active at once.
    task automatic arm(input int di, input int df);
        step();
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        restart  = 1'b1;
        step();
        div_load = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int total;
        repeat (2) step();
        @(negedge clk);
        n_vec++;
        if ({sample_tick, bit_tick, phase, div_err} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got tick=%b bit=%b phase=%0d err=%b, want all 0",
                     sample_tick, bit_tick, phase, div_err);
        end
        step();
        reset = 1'b0;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(400, n);
            total += n;
            n_vec++;
            if (n !== 163) begin
                n_err++;
                $display("FAIL default_period[%0d]: got %0d, want 163", i, n);
            end
            n_vec++;
            if (phase !== 4'(i)) begin
                n_err++;
                $display("FAIL default_phase[%0d]: got %0d, want %0d", i, phase, i);
            end
            n_vec++;
            if (bit_tick !== (i == 15)) begin
                n_err++;
                $display("FAIL bit_tick[%0d]: got %b, want %b", i, bit_tick, (i == 15));
            end
        end
        n_vec++;
        if (total !== 2608) begin
            n_err++;
            $display("FAIL bit_period: got %0d, want 2608", total);
        end
    endtask

    task automatic test_fractional();
        int p[20];
        int m_acc;
        int m_ext;
        int tmp;
        int sum;
        int n;
        step();
        div_int  = 16'd10;
        div_frac = 4'd8;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        restart  = 1'b1;
        step();
        restart  = 1'b0;
        m_acc = 0;
        m_ext = 0;
        for (int k = 0; k < 20; k++) begin
            wait_tick(100, n);
            p[k] = n;
            n_vec++;
            if (n !== 10 + m_ext) begin
                n_err++;
                $display("FAIL frac_period[%0d]: got %0d, want %0d", k, n, 10 + m_ext);
            end
            tmp   = m_acc + 8;
            m_ext = tmp / 16;
            m_acc = tmp % 16;
        end
        for (int s = 1; s <= 4; s++) begin
            sum = 0;
            for (int j = 0; j < 16; j++) sum += p[s + j];
            n_vec++;
            if (sum !== 168) begin
                n_err++;
                $display("FAIL frac_window[%0d]: got %0d, want 168", s, sum);
            end
        end
    endtask

    task automatic test_midperiod_load();
        int n;
        arm(163, 0);
        repeat (50) step();
        div_int  = 16'd5;
        div_frac = 4'd0;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_tick(300, n);
        n_vec++;
        if (n !== 112) begin
            n_err++;
            $display("FAIL midload_current: got %0d, want 112", n);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_tick(300, n);
            n_vec++;
            if (n !== 5 || phase !== 4'(i)) begin
                n_err++;
                $display("FAIL midload_next[%0d]: got period %0d phase %0d, want 5 and %0d",
                         i, n, phase, i);
            end
        end
    endtask

    task automatic test_div_err();
        int n;
        arm(163, 0);
        div_int  = 16'd1;
        div_load = 1'b1;
        @(negedge clk);
        n_vec++;
        if (div_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_before: got %b, want 0", div_err);
        end
        step();
        div_load = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %b, want 1", div_err);
        end
        wait_tick(400, n);
        n_vec++;
        if (n !== 161) begin
            n_err++;
            $display("FAIL err_period0: got %0d, want 161", n);
        end
        wait_tick(400, n);
        n_vec++;
        if (n !== 163 || div_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_period1: got %0d err=%b, want 163 err=1", n, div_err);
        end
        step();
        div_int  = 16'd20;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b, want 0", div_err);
        end
        wait_tick(400, n);
        n_vec++;
        if (n !== 161) begin
            n_err++;
            $display("FAIL err_fix_current: got %0d, want 161", n);
        end
        for (int i = 0; i < 2; i++) begin
            wait_tick(400, n);
            n_vec++;
            if (n !== 20) begin
                n_err++;
                $display("FAIL err_fix_period[%0d]: got %0d, want 20", i, n);
            end
        end
    endtask

    task automatic test_enable();
        int n;
        int t;
        arm(163, 0);
        repeat (80) step();
        en = 1'b0;
        t = 0;
        repeat (30) begin
            @(negedge clk);
            if (sample_tick) t++;
            step();
        end
        n_vec++;
        if (t !== 0) begin
            n_err++;
            $display("FAIL en_hold_ticks: got %0d, want 0", t);
        end
        en = 1'b1;
        wait_tick(400, n);
        n_vec++;
        if (n !== 83) begin
            n_err++;
            $display("FAIL en_resume: got %0d, want 83", n);
        end
        arm(163, 0);
        repeat (3) step();
        en       = 1'b0;
        div_int  = 16'd7;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        en = 1'b1;
        wait_tick(400, n);
        n_vec++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL en_load_now: got %0d, want 4", n);
        end
        wait_tick(400, n);
        n_vec++;
        if (n !== 7) begin
            n_err++;
            $display("FAIL en_load_next: got %0d, want 7", n);
        end
    endtask

    task automatic test_restart();
        int n;
        arm(163, 0);
        repeat (7) wait_tick(400, n);
        n_vec++;
        if (n !== 163 || phase !== 4'd6) begin
            n_err++;
            $display("FAIL rst_prep: got period %0d phase %0d, want 163 and 6", n, phase);
        end
        step();
        repeat (100) step();
        restart = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sample_tick !== 1'b0) begin
            n_err++;
            $display("FAIL restart_tick: got %b, want 0", sample_tick);
        end
        step();
        restart = 1'b0;
        wait_tick(400, n);
        n_vec++;
        if (n !== 163 || phase !== 4'd0) begin
            n_err++;
            $display("FAIL restart_after: got period %0d phase %0d, want 163 and 0", n, phase);
        end
        arm(4, 0);
        repeat (3) step();
        restart = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sample_tick !== 1'b0) begin
            n_err++;
            $display("FAIL restart_priority: got %b, want 0", sample_tick);
        end
        step();
        restart = 1'b0;
        wait_tick(100, n);
        n_vec++;
        if (n !== 4 || phase !== 4'd0) begin
            n_err++;
            $display("FAIL restart_prio_after: got period %0d phase %0d, want 4 and 0", n, phase);
        end
        arm(12, 0);
        wait_tick(100, n);
        n_vec++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL load_restart: got %0d, want 12", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        arm(163, 0);
        repeat (162) step();
        div_int  = 16'd6;
        div_load = 1'b1;
        @(negedge clk);
        n_vec++;
        if (sample_tick !== 1'b1) begin
            n_err++;
            $display("FAIL tick_load_tick: got %b, want 1", sample_tick);
        end
        step();
        div_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_tick(400, n);
            n_vec++;
            if (n !== 6) begin
                n_err++;
                $display("FAIL tick_load_period[%0d]: got %0d, want 6", i, n);
            end
        end
        arm(163, 0);
        step();
        div_int  = 16'd30;
        div_load = 1'b1;
        step();
        div_int  = 16'd40;
        step();
        div_load = 1'b0;
        wait_tick(400, n);
        n_vec++;
        if (n !== 160) begin
            n_err++;
            $display("FAIL last_wins_current: got %0d, want 160", n);
        end
        wait_tick(400, n);
        n_vec++;
        if (n !== 40) begin
            n_err++;
            $display("FAIL last_wins_next: got %0d, want 40", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        arm(163, 0);
        repeat (10) step();
        div_int  = 16'd9;
        div_load = 1'b1;
        step();
        div_int  = 16'd0;
        step();
        div_load = 1'b0;
        @(negedge clk);
        n_vec++;
        if (div_err !== 1'b1) begin
            n_err++;
            $display("FAIL mid_err_set: got %b, want 1", div_err);
        end
        repeat (20) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        n_vec++;
        if ({sample_tick, bit_tick, phase, div_err} !== 7'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got tick=%b bit=%b phase=%0d err=%b, want all 0",
                     sample_tick, bit_tick, phase, div_err);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_tick(400, n);
            n_vec++;
            if (n !== 163) begin
                n_err++;
                $display("FAIL mid_reset_period[%0d]: got %0d, want 163", i, n);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        restart  = 1'b0;
        div_load = 1'b0;
        div_int  = '0;
        div_frac = '0;
        test_reset();
        test_fractional();
        test_midperiod_load();
        test_div_err();
        test_enable();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
